// File: rtl/mcs4_timing_pkg.sv
// Shared types and constants for the 4004 timing sequencer.
package mcs4_timing_pkg;

  typedef enum logic [2:0] {
    A1 = 3'd0, A2, A3, M1, M2, X1, X2, X3
  } subcycle_e;

  typedef enum logic [1:0] {
    SLOT_CLK1, SLOT_GAP1, SLOT_CLK2, SLOT_GAP2
  } slot_e;

  typedef enum logic [1:0] {
    RUN, HALTED, STEP
  } halt_state_e;

  localparam int SLOTS_PER_SUB  = 4;
  localparam int SUBS_PER_CYCLE = 8;

  function automatic logic [SUBS_PER_CYCLE-1:0] strobe_onehot(input subcycle_e s);
    return SUBS_PER_CYCLE'(1) << s;
  endfunction

endpackage

// File: rtl/phase_gen.sv
// Phase-slot generator: CLK_DIV divider, slot counter and the clk1/clk2 levels.
module phase_gen
  import mcs4_timing_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic  sysclk,
  input  logic  poc_n,
  input  logic  freeze,
  output logic  clk1,
  output logic  clk2,
  output slot_e slot,
  output logic  slot_start,
  output logic  slot_end
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_q;
  logic [1:0]    slot_q;

  // Counters point at the position the next edge displays, so outputs lag them by one sysclk.
  assign slot       = slot_e'(slot_q);
  assign slot_start = (div_q == '0);
  assign slot_end   = (div_q == DW'(CLK_DIV - 1)) && (slot_q == 2'(SLOTS_PER_SUB - 1));

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      div_q  <= '0;
      slot_q <= 2'd0;
      clk1   <= 1'b0;
      clk2   <= 1'b0;
    end else if (freeze) begin
      clk1 <= 1'b0;
      clk2 <= 1'b0;
    end else begin
      clk1 <= (slot == SLOT_CLK1);
      clk2 <= (slot == SLOT_CLK2);
      if (div_q == DW'(CLK_DIV - 1)) begin
        div_q  <= '0;
        slot_q <= slot_q + 2'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timing_generator.sv
// 4004 master timing sequencer: subcycle sequence, state strobes, SYNC, POC stretch, run/halt/step.
//
// state  | meaning
// RUN    | free-running; halts at the X3->A1 wrap if run=0 there
// HALTED | frozen at A1 slot 0, clocks low, x32 held; run or step releases
// STEP   | executing one released instruction cycle; re-halts at the wrap unless run=1
module timing_generator
  import mcs4_timing_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int POC_CYCLES = 4
) (
  input  logic sysclk,
  input  logic poc_n,
  input  logic run,
  input  logic step,
  output logic halted,
  output logic clk1,
  output logic clk2,
  output logic sync,
  output logic a12,
  output logic a22,
  output logic a32,
  output logic m12,
  output logic m22,
  output logic x12,
  output logic x22,
  output logic x32,
  output logic poc
);

  subcycle_e                 sub_q;
  halt_state_e               state_q;
  logic [3:0]                poc_cnt_q;
  logic [SUBS_PER_CYCLE-1:0] strobe_q;

  slot_e slot;
  logic  slot_start;
  logic  slot_end;
  logic  freeze;
  logic  wrap;

  assign freeze = (state_q == HALTED) && !(run || step);
  assign wrap   = slot_end && (sub_q == X3);

  assign {x32, x22, x12, m22, m12, a32, a22, a12} = strobe_q;

  phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_gen (
    .sysclk     (sysclk),
    .poc_n      (poc_n),
    .freeze     (freeze),
    .clk1       (clk1),
    .clk2       (clk2),
    .slot       (slot),
    .slot_start (slot_start),
    .slot_end   (slot_end)
  );

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      state_q   <= RUN;
      halted    <= 1'b0;
      sub_q     <= A1;
      strobe_q  <= '0;
      sync      <= 1'b0;
      poc       <= 1'b1;
      poc_cnt_q <= 4'(POC_CYCLES);
    end else if (freeze) begin
      sync <= 1'b0;
    end else begin
      sync <= (sub_q == X3);
      poc  <= (poc_cnt_q != 4'd0);
      if (slot_start && (slot == SLOT_CLK2))
        strobe_q <= strobe_onehot(sub_q);
      if (slot_end)
        sub_q <= subcycle_e'(3'(sub_q + 3'd1));
      if (wrap && (poc_cnt_q != 4'd0))
        poc_cnt_q <= poc_cnt_q - 4'd1;

      case (state_q)
        RUN: begin
          if (wrap && !run) begin
            state_q <= HALTED;
            halted  <= 1'b1;
          end
        end
        HALTED: begin
          // Only reached here on a release; run wins over step.
          state_q <= run ? RUN : STEP;
          halted  <= 1'b0;
        end
        STEP: begin
          if (wrap) begin
            state_q <= run ? RUN : HALTED;
            halted  <= !run;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule
